display_scan_ctrl: RTL and testbench

- Sequencer that drives the 7-segment display mux: generates the digit select (Array) for the 3-slot scan (upper nibble, lower nibble, mode letter), with an anti-ghosting blank interval in each slot.
- Captures received bytes and the transmit staging byte, and debounces the Rx/Tx mode switch.
- Updates every displayed value only at frame boundaries so no frame shows mixed data.
- Sits between the UART Rx/Tx logic and the display decoder; its outputs connect directly to the decoder's Rx_Data, Tx_Data, Array and Mode inputs.

---
 rtl/display_scan_ctrl.sv | 107 ++++++++++
 tb/tb_display_scan_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Display scan sequencer: 3-slot digit select with blanking, frame-aligned
// Rx/Tx byte capture and a debounced, frame-aligned mode switch.
module display_scan_ctrl #(
    parameter int unsigned DIGIT_CYCLES    = 100000,
    parameter int unsigned BLANK_CYCLES    = 1000,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    input  logic [7:0] tx_byte,
    input  logic       mode_sw,
    output logic [7:0] Rx_Data,
    output logic [7:0] Tx_Data,
    output logic [1:0] Array,
    output logic       Mode,
    output logic       frame_tick
);

    localparam int unsigned CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [1:0]    slot;
    logic [1:0]    slot_nxt;
    logic [1:0]    array_nxt;
    logic          boundary;

    logic [7:0]    rx_hold;
    logic          rx_pend;

    logic          sync_meta;
    logic          sync_mode;
    logic          stable_mode;
    logic [DW-1:0] deb_cnt;

    // Next scan position; Array is registered from it so it lines up with (slot, cnt)
    always_comb begin
        cnt_nxt   = cnt + CW'(1);
        slot_nxt  = slot;
        boundary  = 1'b0;
        if (cnt == CW'(DIGIT_CYCLES - 1)) begin
            cnt_nxt  = '0;
            slot_nxt = (slot == 2'd2) ? 2'd0 : slot + 2'd1;
            boundary = (slot == 2'd2);
        end
        array_nxt = (cnt_nxt < CW'(BLANK_CYCLES)) ? 2'd3 : slot_nxt;
    end

    // Scan counter, digit select and frame-aligned display registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            slot       <= 2'd0;
            Array      <= 2'd3;
            frame_tick <= 1'b0;
            Rx_Data    <= 8'h00;
            Tx_Data    <= 8'h00;
            Mode       <= 1'b0;
            rx_hold    <= 8'h00;
            rx_pend    <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            slot       <= slot_nxt;
            Array      <= array_nxt;
            frame_tick <= boundary;
            if (boundary) begin
                Tx_Data <= tx_byte;
                Mode    <= stable_mode;
                rx_pend <= 1'b0;
                // A byte arriving on the boundary edge is newer than anything held
                if (rx_valid) begin
                    Rx_Data <= rx_byte;
                end else if (rx_pend) begin
                    Rx_Data <= rx_hold;
                end
            end else if (rx_valid) begin
                rx_hold <= rx_byte;
                rx_pend <= 1'b1;
            end
        end
    end

    // Switch synchronizer and debounce: accept a level only after it holds steadily
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta   <= 1'b0;
            sync_mode   <= 1'b0;
            stable_mode <= 1'b0;
            deb_cnt     <= '0;
        end else begin
            sync_meta <= mode_sw;
            sync_mode <= sync_meta;
            if (sync_mode == stable_mode) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                stable_mode <= sync_mode;
                deb_cnt     <= '0;
            end else begin
                deb_cnt <= deb_cnt + DW'(1);
            end
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized bench for display_scan_ctrl against a frame-level reference model.
module tb_display_scan_ctrl;

    localparam int unsigned DC    = 8;
    localparam int unsigned BC    = 2;
    localparam int unsigned DB    = 4;
    localparam int unsigned FRAME = 3 * DC;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] tx_byte = 8'h00;
    logic       mode_sw = 1'b0;
    logic [7:0] Rx_Data;
    logic [7:0] Tx_Data;
    logic [1:0] Array;
    logic       Mode;
    logic       frame_tick;

    display_scan_ctrl #(
        .DIGIT_CYCLES   (DC),
        .BLANK_CYCLES   (BC),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .tx_byte   (tx_byte),
        .mode_sw   (mode_sw),
        .Rx_Data   (Rx_Data),
        .Tx_Data   (Tx_Data),
        .Array     (Array),
        .Mode      (Mode),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: t = cycles since reset release
    int         t;
    logic [7:0] m_rx, m_tx, m_hold;
    bit         m_pend, m_mode, m_stable, sw_d1, sw_d2;
    int         run;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
    endtask

    task automatic model_reset();
        t = 0; m_rx = 8'h00; m_tx = 8'h00; m_hold = 8'h00;
        m_pend = 1'b0; m_mode = 1'b0; m_stable = 1'b0;
        sw_d1 = 1'b0; sw_d2 = 1'b0; run = 0;
    endtask

    task automatic check_cycle();
        int unsigned pos;
        logic [1:0]  exp_arr;
        pos     = t % FRAME;
        exp_arr = ((pos % DC) < BC) ? 2'd3 : 2'(pos / DC);
        check("array", 32'(Array), 32'(exp_arr));
        check("frame_tick", 32'(frame_tick), 32'((t != 0) && (pos == 0)));
        check("rx_data", 32'(Rx_Data), 32'(m_rx));
        check("tx_data", 32'(Tx_Data), 32'(m_tx));
        check("mode", 32'(Mode), 32'(m_mode));
    endtask

    // Apply one cycle of inputs, advance the model across the edge, then check
    task automatic step(input bit v, input logic [7:0] b, input logic [7:0] txb, input bit sw);
        bit synced;
        rx_valid = v; rx_byte = b; tx_byte = txb; mode_sw = sw;
        @(posedge clk);
        if (((t + 1) % FRAME) == 0) begin
            if (v) begin
                m_rx = b; m_pend = 1'b0;
            end else if (m_pend) begin
                m_rx = m_hold; m_pend = 1'b0;
            end
            m_tx   = txb;
            m_mode = m_stable;
        end else if (v) begin
            m_hold = b; m_pend = 1'b1;
        end
        synced = sw_d2;
        if (synced != m_stable) begin
            run++;
            if (run == DB) begin
                m_stable = synced; run = 0;
            end
        end else begin
            run = 0;
        end
        sw_d2 = sw_d1; sw_d1 = sw;
        t++;
        @(negedge clk);
        check_cycle();
    endtask

    initial begin
        bit sw;
        model_reset();
        sw = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_array", 32'(Array), 32'd3);
        check("rst_rx", 32'(Rx_Data), 32'h0);
        reset = 1'b0;
        check_cycle();

        // Scan-only frames with idle inputs
        for (int i = 0; i < 2 * FRAME; i++) step(1'b0, 8'h00, 8'h00, 1'b0);

        // Random traffic with a bouncy switch
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(5) == 0) sw = ~sw;
            step($urandom_range(3) == 0, 8'($urandom), 8'($urandom), sw);
        end

        // Settle Mode=1, then leave a byte pending just before a mid-frame reset
        for (int i = 0; i < 2 * FRAME; i++)
            step($urandom_range(3) == 0, 8'($urandom), 8'($urandom), 1'b1);
        for (int i = 0; i < FRAME && (t % FRAME) != 12; i++)
            step(1'b0, 8'h00, 8'($urandom), 1'b1);
        step(1'b1, 8'hC3, 8'($urandom), 1'b1);
        check("pre_rst_mode", 32'(Mode), 32'd1);
        rx_valid = 1'b0;
        mode_sw  = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("async_array", 32'(Array), 32'd3);
        check("async_tick", 32'(frame_tick), 32'd0);
        check("async_rx", 32'(Rx_Data), 32'h0);
        check("async_tx", 32'(Tx_Data), 32'h0);
        check("async_mode", 32'(Mode), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check_cycle();
        for (int i = 0; i < FRAME + 6; i++) step(1'b0, 8'h00, 8'($urandom), 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
